// File: rtl/sdram_port_arbiter_pkg.sv
// Shared types for the two-master SDRAM port arbiter.
package sdram_arb_pkg;
  typedef enum logic [1:0] {IDLE, BUSY_M0, BUSY_M1} arb_state_t;
  typedef logic owner_t;
  localparam owner_t M0 = 1'b0;
  localparam owner_t M1 = 1'b1;
endpackage

// File: rtl/sdram_port_arbiter_if.sv
// Single-word Avalon-MM port: the master modport issues commands, the slave modport answers.
interface sdram_port_arbiter_if #(
  parameter int ADDR_W = 23,
  parameter int DATA_W = 32,
  parameter int BE_W   = 4
);
  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic [BE_W-1:0]   byteenable;
  logic              waitrequest;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;

  modport master (output address, read, write, writedata, byteenable,
                  input  waitrequest, readdata, readdatavalid);
  modport slave  (input  address, read, write, writedata, byteenable,
                  output waitrequest, readdata, readdatavalid);
endinterface

// File: rtl/sdram_port_arbiter_owner_fifo.sv
// In-order record of which master issued each outstanding read.
module arb_owner_fifo
  import sdram_arb_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push,
  input  owner_t  push_data,
  input  logic    pop,
  output owner_t  head,
  output logic    empty,
  output logic    full,
  output logic [AW:0] count
);
  owner_t mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;

  // A pop in the same cycle frees the slot, so a full FIFO still takes a push.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter sharing one SDRAM controller port between two masters,
// with in-order routing of pipelined read data.
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_W      = 23,
  parameter int DATA_W      = 32,
  parameter int BE_W        = 4,
  parameter int MAX_PENDING = 8
) (
  input  logic clk_clk,
  input  logic reset_reset,
  sdram_port_arbiter_if.slave  m0,
  sdram_port_arbiter_if.slave  m1,
  sdram_port_arbiter_if.master s,
  output logic err_unexpected_rdv
);
  localparam int PEND_W = $clog2(MAX_PENDING) + 1;

  arb_state_t state, state_d;
  owner_t     last, grant, cur, head;
  logic       grant_vld, accept, cand0, cand1;
  logic       fifo_empty, fifo_full;
  logic [PEND_W-1:0] pending;

  logic [ADDR_W-1:0] s_address_q;
  logic [DATA_W-1:0] s_writedata_q;
  logic [BE_W-1:0]   s_byteenable_q;
  logic              s_read_q, s_write_q;

  assign cur    = (state == BUSY_M1) ? M1 : M0;
  assign accept = (state != IDLE) && !s.waitrequest;
  // Registered occupancy: a beat returning this cycle frees a slot only next cycle.
  assign cand0  = m0.write || (m0.read && !fifo_full);
  assign cand1  = m1.write || (m1.read && !fifo_full);

  always_comb begin
    state_d   = state;
    grant_vld = 1'b0;
    grant     = M0;
    case (state)
      IDLE: begin
        if (cand0 && cand1) begin
          grant_vld = 1'b1;
          grant     = (last == M1) ? M0 : M1;
        end else if (cand0 || cand1) begin
          grant_vld = 1'b1;
          grant     = cand0 ? M0 : M1;
        end
        if (grant_vld) state_d = (grant == M1) ? BUSY_M1 : BUSY_M0;
      end
      BUSY_M0, BUSY_M1: if (!s.waitrequest) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state              <= IDLE;
      last               <= M1;
      s_address_q        <= '0;
      s_writedata_q      <= '0;
      s_byteenable_q     <= '0;
      s_read_q           <= 1'b0;
      s_write_q          <= 1'b0;
      err_unexpected_rdv <= 1'b0;
    end else begin
      state <= state_d;
      if (grant_vld) begin
        s_address_q    <= (grant == M1) ? m1.address    : m0.address;
        s_writedata_q  <= (grant == M1) ? m1.writedata  : m0.writedata;
        s_byteenable_q <= (grant == M1) ? m1.byteenable : m0.byteenable;
        s_read_q       <= (grant == M1) ? m1.read       : m0.read;
        s_write_q      <= (grant == M1) ? m1.write      : m0.write;
      end else if (accept) begin
        s_read_q  <= 1'b0;
        s_write_q <= 1'b0;
        last      <= cur;
      end
      if (s.readdatavalid && fifo_empty) err_unexpected_rdv <= 1'b1;
    end
  end

  arb_owner_fifo #(.DEPTH(MAX_PENDING)) u_owner_fifo (
    .clk       (clk_clk),
    .rst       (reset_reset),
    .push      (accept && s_read_q),
    .push_data (cur),
    .pop       (s.readdatavalid),
    .head      (head),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (pending)
  );

  assign s.address    = s_address_q;
  assign s.writedata  = s_writedata_q;
  assign s.byteenable = s_byteenable_q;
  assign s.read       = s_read_q;
  assign s.write      = s_write_q;

  // Master and controller complete the handshake in the same cycle.
  assign m0.waitrequest   = !((state == BUSY_M0) && !s.waitrequest);
  assign m1.waitrequest   = !((state == BUSY_M1) && !s.waitrequest);
  assign m0.readdata      = s.readdata;
  assign m1.readdata      = s.readdata;
  assign m0.readdatavalid = s.readdatavalid && (pending != '0) && (head == M0);
  assign m1.readdatavalid = s.readdatavalid && (pending != '0) && (head == M1);
endmodule

// File: doc/sdram_port_arbiter.md
# sdram_port_arbiter

Two-requester Avalon-MM arbiter that shares the single SDRAM controller slave port between the Nios CPU data master (m0) and a hardware streaming engine (m1). It grants single-word transfers round-robin, holds each command stable until the controller accepts it, and routes pipelined read responses back to the issuing master in order. It sits between the requesters and the SDRAM controller inside the clk_clk domain produced by the PLL.

## Interface
- ADDR_W, 23: word address width (8M x 32-bit SDRAM).
- DATA_W, 32: data width.
- BE_W, 4: byteenable width, DATA_W/8.
- MAX_PENDING, 8: maximum outstanding reads; power of two, at least 2.

Ports:
- clk_clk  in  1  system clock (PLL c0).
- reset_reset  in  1  synchronous, active-high reset.
- mN_address  in  ADDR_W  master N word address (N = 0, 1).
- mN_read, mN_write  in  1  master N command strobes; never both high.
- mN_writedata  in  DATA_W, mN_byteenable  in  BE_W  master N write payload.
- mN_waitrequest  out  1  low for the single cycle master N's command is accepted.
- mN_readdata  out  DATA_W  equals s_readdata.
- mN_readdatavalid  out  1  read response for master N.
- s_address  out  ADDR_W; s_read, s_write  out  1; s_writedata  out  DATA_W; s_byteenable  out  BE_W  registered command to the controller.
- s_waitrequest  in  1; s_readdata  in  DATA_W; s_readdatavalid  in  1  controller responses.
- err_unexpected_rdv  out  1  sticky; set when s_readdatavalid arrives with no outstanding read.

## Operation
- FSM states: IDLE, BUSY_M0, BUSY_M1.
- IDLE: candidates are masters with write high, or read high and pending < MAX_PENDING. One candidate gets the grant. Two candidates: the master not served last wins. The `last` pointer resets to 1, so m0 wins the first tie. On grant, the master's command is latched into the s_* registers and the FSM moves to BUSY_Mx.
- BUSY_Mx: s_read/s_write are held from the latch and are stable while s_waitrequest is high. The transfer is accepted on a cycle with s_waitrequest low. mx_waitrequest = !s_waitrequest in that state only; it is combinational, so master and controller accept in the same cycle. On acceptance: s_read/s_write go to 0 next cycle, `last` becomes x, the FSM returns to IDLE, and an accepted read pushes owner x into the owner FIFO.
- mN_waitrequest is high in every other state and cycle.
- Read return: mN_readdatavalid = s_readdatavalid and (FIFO head == N) and FIFO not empty. Each returned beat pops the FIFO.
- Simultaneous push and pop in one cycle: the count is unchanged and both take effect.
- Full FIFO (pending == MAX_PENDING): new reads are not granted. Writes are still granted.
- A returned beat in the same cycle a read is evaluated in IDLE does not unblock that read. The read is eligible the next cycle.
- s_readdatavalid with an empty FIFO: ignored, no mN_readdatavalid, err_unexpected_rdv set until reset.
- Reset mid-operation, including with pending reads: FIFO flushed, FSM to IDLE, later stray responses raise err_unexpected_rdv.

## Timing
- Reset values: FSM IDLE; s_read = s_write = 0; s_address, s_writedata, s_byteenable = 0; mN_waitrequest = 1; mN_readdatavalid = 0; err_unexpected_rdv = 0; `last` = 1; pending = 0.
- Command latency: request visible at edge k, s_* asserted from cycle k+1. With s_waitrequest low, master acceptance occurs in cycle k+1.
- Peak throughput: one command per 2 cycles.
- Read data path: zero added latency, combinational from the s_readdatavalid/s_readdata inputs.
- pending is a $clog2(MAX_PENDING)+1 bit counter. It must never exceed MAX_PENDING or underflow.

## Structure
- Package sdram_arb_pkg holds:
  - arb_state_t enum {IDLE, BUSY_M0, BUSY_M1}
  - owner_t (1 bit)
  - localparams M0 = 0, M1 = 1
- Sub-module arb_owner_fifo: synchronous FIFO of owner_t, depth MAX_PENDING, with push, pop, head, empty, full, and count. It supports simultaneous push/pop when full, because a pop frees the slot.

## Test plan
- Single writes: m0 writes 0x000010/0xDEADBEEF with s_waitrequest low -> s_write high for exactly 1 cycle with that address/data; m0_waitrequest low in the same cycle; m1 untouched.
- Contention: both masters request continuous reads; controller returns data after 3 cycles -> grants alternate m0, m1, m0, m1. Each readdatavalid goes only to its issuer, in issue order.
- Backpressure: s_waitrequest held high 5 cycles during a BUSY_M1 write -> s_* stable for all 6 cycles; m1_waitrequest low only on cycle 6; m0 gets no grant meanwhile.
- FIFO full: m0 issues 8 reads while the controller withholds data -> 9th read stalls (m0_waitrequest high) while an m1 write is still granted. The first returned beat pops, and the 9th read is granted on the following IDLE cycle.
- Stray response: s_readdatavalid pulse with nothing pending -> no mN_readdatavalid; err_unexpected_rdv = 1 and stays set until reset.
- Reset mid-flight: 3 reads pending, assert reset_reset 1 cycle -> all outputs at reset values next cycle. A subsequent s_readdatavalid sets err_unexpected_rdv; a new m1 read completes normally.
